// File: rtl/acc_mc_core.sv
// acc_mc_core: multicycle accumulator core (FETCH/DECODE/MEM_R/EXEC/MEM_W/HALT)
// sharing one req/ack memory port for instruction fetch, operand read and store.
module acc_mc_core #(
   parameter int unsigned    DW       = 16,
   parameter int unsigned    AW       = 13,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          halted,
   output logic [AW-1:0] dbg_pc,
   output logic [DW-1:0] dbg_acc
);

   localparam int unsigned OPW = 3;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_MEM_R  = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM_W  = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [OPW-1:0] OP_LDA = 3'b000;
   localparam logic [OPW-1:0] OP_STA = 3'b001;
   localparam logic [OPW-1:0] OP_ADD = 3'b010;
   localparam logic [OPW-1:0] OP_SUB = 3'b011;
   localparam logic [OPW-1:0] OP_JMP = 3'b100;
   localparam logic [OPW-1:0] OP_JZ  = 3'b101;
   localparam logic [OPW-1:0] OP_AND = 3'b110;
   localparam logic [OPW-1:0] OP_HLT = 3'b111;

   logic [2:0]    state, state_nxt;
   logic [AW-1:0] pc, pc_nxt;
   logic [DW-1:0] acc, acc_nxt;
   logic          z, z_nxt;
   logic [DW-1:0] ir, ir_nxt;
   logic [DW-1:0] mdr, mdr_nxt;

   logic [OPW-1:0] opcode;
   logic [AW-1:0]  opnd;

   assign opcode = ir[DW-1 -: OPW];
   assign opnd   = ir[AW-1:0];

   // State and datapath registers; synchronous reset abandons any open transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         acc   <= '0;
         z     <= 1'b1;
         ir    <= '0;
         mdr   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         acc   <= acc_nxt;
         z     <= z_nxt;
         ir    <= ir_nxt;
         mdr   <= mdr_nxt;
      end
   end

   // Next-state and datapath update; memory-facing states only advance on ack
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      acc_nxt   = acc;
      z_nxt     = z;
      ir_nxt    = ir;
      mdr_nxt   = mdr;
      case (state)
         S_FETCH: begin
            if (mem_ack) begin
               ir_nxt    = mem_rdata;
               pc_nxt    = pc + AW'(1);
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_JMP: begin
                  pc_nxt    = opnd;
                  state_nxt = S_FETCH;
               end
               OP_JZ: begin
                  if (z) pc_nxt = opnd;
                  state_nxt = S_FETCH;
               end
               OP_HLT:  state_nxt = S_HALT;
               OP_STA:  state_nxt = S_MEM_W;
               default: state_nxt = S_MEM_R;
            endcase
         end
         S_MEM_R: begin
            if (mem_ack) begin
               mdr_nxt   = mem_rdata;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_ADD:  acc_nxt = acc + mdr;
               OP_SUB:  acc_nxt = acc - mdr;
               OP_AND:  acc_nxt = acc & mdr;
               OP_LDA:  acc_nxt = mdr;
               default: acc_nxt = acc;
            endcase
            z_nxt     = (acc_nxt == '0);
            state_nxt = S_FETCH;
         end
         S_MEM_W: begin
            if (mem_ack) state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   // Memory port decode: from state and registers only, request gated off in reset
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = (state == S_FETCH) ? pc : opnd;
      mem_wdata = acc;
      if (!rst) begin
         mem_req = (state == S_FETCH) || (state == S_MEM_R) || (state == S_MEM_W);
         mem_we  = (state == S_MEM_W);
      end
   end

   assign halted  = (state == S_HALT);
   assign dbg_pc  = pc;
   assign dbg_acc = acc;

endmodule

// File: tb/tb_acc_mc_core.sv
// tb_acc_mc_core: directed programs on two core configurations with a
// wait-state memory model and a transaction scoreboard.
module tb_acc_mc_core;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] acc;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic        rst_v    [2];
   int          wait_cfg [2];
   logic        hold_wr  [2];
   int          wcnt     [2] = '{0, 0};
   logic [15:0] mem      [2][0:8191];
   txn_t        exp_q    [2][$];

   // Core A: default 16/13 configuration
   logic        req_a, we_a, ack_a, hlt_a;
   logic [12:0] addr_a, pc_a;
   logic [15:0] wdata_a, acc_a, rdata_a;
   // Core B: 12/8 configuration starting at the top of memory
   logic        req_b, we_b, ack_b, hlt_b;
   logic [7:0]  addr_b, pc_b;
   logic [11:0] wdata_b, acc_b, rdata_b;

   logic        req [2], we [2], ack [2], hlt [2];
   logic [15:0] addr [2], wdata [2], acc [2], pc [2];

   acc_mc_core u_dut_a (
      .clk(clk), .rst(rst_v[0]),
      .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .mem_rdata(rdata_a), .mem_ack(ack_a),
      .halted(hlt_a), .dbg_pc(pc_a), .dbg_acc(acc_a)
   );

   acc_mc_core #(.DW(12), .AW(8), .RESET_PC(8'hFF)) u_dut_b (
      .clk(clk), .rst(rst_v[1]),
      .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .mem_rdata(rdata_b), .mem_ack(ack_b),
      .halted(hlt_b), .dbg_pc(pc_b), .dbg_acc(acc_b)
   );

   assign req[0] = req_a;  assign req[1] = req_b;
   assign we[0]  = we_a;   assign we[1]  = we_b;
   assign ack[0] = ack_a;  assign ack[1] = ack_b;
   assign hlt[0] = hlt_a;  assign hlt[1] = hlt_b;
   assign addr[0]  = 16'(addr_a);  assign addr[1]  = 16'(addr_b);
   assign wdata[0] = 16'(wdata_a); assign wdata[1] = 16'(wdata_b);
   assign acc[0]   = 16'(acc_a);   assign acc[1]   = 16'(acc_b);
   assign pc[0]    = 16'(pc_a);    assign pc[1]    = 16'(pc_b);

   // Memory model: ack after wait_cfg wait cycles; writes can be withheld forever
   assign ack_a   = req_a && !(hold_wr[0] && we_a) && (wcnt[0] >= wait_cfg[0]);
   assign ack_b   = req_b && !(hold_wr[1] && we_b) && (wcnt[1] >= wait_cfg[1]);
   assign rdata_a = mem[0][addr_a];
   assign rdata_b = mem[1][addr_b][11:0];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (req[k] && !ack[k]) wcnt[k] <= wcnt[k] + 1;
         else                   wcnt[k] <= 0;
         if (req[k] && ack[k] && we[k]) mem[k][addr[k][12:0]] = wdata[k];
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
   endtask

   // Scoreboard monitor: every request cycle must match the head expected transaction
   always @(negedge clk) begin
      txn_t e, g;
      for (int k = 0; k < 2; k++) begin
         if (rst_v[k]) begin
            chk($sformatf("req_in_reset[%0d]", k), 64'(req[k]), 64'd0);
         end else if (req[k]) begin
            if (exp_q[k].size() == 0) begin
               chk($sformatf("unexpected_req[%0d] addr=0x%0h", k, addr[k]), 64'(req[k]), 64'd0);
            end else begin
               e = exp_q[k][0];
               g.we    = we[k];
               g.addr  = addr[k];
               g.wdata = we[k] ? wdata[k] : 16'd0;
               g.acc   = acc[k];
               chk($sformatf("txn[%0d] {we,addr,wdata,acc}", k), 64'(g), 64'(e));
               if (ack[k]) void'(exp_q[k].pop_front());
            end
         end
      end
   end

   task automatic expect_txn(input int k, input logic w, input int a, input int d, input int ac);
      txn_t t;
      t.we    = w;
      t.addr  = 16'(a);
      t.wdata = 16'(d);
      t.acc   = 16'(ac);
      exp_q[k].push_back(t);
   endtask

   task automatic clear_mem(input int k);
      for (int i = 0; i < 8192; i++) mem[k][i] = 16'd0;
   endtask

   task automatic enter_reset(input int k);
      @(posedge clk); #1;
      rst_v[k] = 1'b1;
      exp_q[k].delete();
      @(posedge clk); #1;
   endtask

   task automatic run_to_halt(input int k, input int exp_cyc, input string nm);
      int n = 0;
      rst_v[k] = 1'b0;
      while (!hlt[k] && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_halt_cycle"}, 64'(n), 64'(exp_cyc));
      repeat (4) @(posedge clk);
      #1;
      chk({nm, "_txns_left"}, 64'(exp_q[k].size()), 64'd0);
   endtask

   task automatic load_basic();
      clear_mem(0);
      mem[0][0] = 16'h000A;   // LDA 10
      mem[0][1] = 16'h400B;   // ADD 11
      mem[0][2] = 16'h200C;   // STA 12
      mem[0][3] = 16'hE000;   // HLT
      mem[0][10] = 16'd5;
      mem[0][11] = 16'd7;
      expect_txn(0, 0, 0, 0, 0);
      expect_txn(0, 0, 10, 0, 0);
      expect_txn(0, 0, 1, 0, 5);
      expect_txn(0, 0, 11, 0, 5);
      expect_txn(0, 0, 2, 0, 12);
      expect_txn(0, 1, 12, 12, 12);
      expect_txn(0, 0, 3, 0, 12);
   endtask

   initial begin
      int n;
      rst_v[0] = 1'b1;  rst_v[1] = 1'b1;
      wait_cfg[0] = 0;  wait_cfg[1] = 0;
      hold_wr[0] = 1'b0; hold_wr[1] = 1'b0;

      // Basic program, zero-wait memory
      enter_reset(0);
      chk("rst_pc", 64'(pc[0]), 64'd0);
      chk("rst_acc", 64'(acc[0]), 64'd0);
      chk("rst_halted", 64'(hlt[0]), 64'd0);
      load_basic();
      run_to_halt(0, 13, "basic");
      chk("basic_acc", 64'(acc[0]), 64'd12);
      chk("basic_m12", 64'(mem[0][12]), 64'd12);

      // Same program, three wait states per access, restarted from HALT
      wait_cfg[0] = 3;
      enter_reset(0);
      chk("restart_halted", 64'(hlt[0]), 64'd0);
      load_basic();
      run_to_halt(0, 34, "wait3");
      chk("wait3_acc", 64'(acc[0]), 64'd12);
      chk("wait3_m12", 64'(mem[0][12]), 64'd12);
      wait_cfg[0] = 0;

      // SUB underflow, JZ fall-through and taken
      enter_reset(0);
      clear_mem(0);
      mem[0][0] = 16'h001E;   // LDA 30
      mem[0][1] = 16'h601F;   // SUB 31
      mem[0][2] = 16'hA014;   // JZ 20 (not taken)
      mem[0][3] = 16'h6020;   // SUB 32
      mem[0][4] = 16'hA014;   // JZ 20 (taken)
      mem[0][20] = 16'hE000;  // HLT
      mem[0][30] = 16'd3;
      mem[0][31] = 16'd5;
      mem[0][32] = 16'hFFFE;
      expect_txn(0, 0, 0, 0, 0);
      expect_txn(0, 0, 30, 0, 0);
      expect_txn(0, 0, 1, 0, 3);
      expect_txn(0, 0, 31, 0, 3);
      expect_txn(0, 0, 2, 0, 16'hFFFE);
      expect_txn(0, 0, 3, 0, 16'hFFFE);
      expect_txn(0, 0, 32, 0, 16'hFFFE);
      expect_txn(0, 0, 4, 0, 0);
      expect_txn(0, 0, 20, 0, 0);
      run_to_halt(0, 18, "sub_jz");
      chk("sub_jz_acc", 64'(acc[0]), 64'd0);

      // LDA of zero and AND to zero set Z; JMP
      enter_reset(0);
      clear_mem(0);
      mem[0][0]  = 16'h0029;  // LDA 41
      mem[0][1]  = 16'hA005;  // JZ 5 (not taken)
      mem[0][2]  = 16'h0028;  // LDA 40
      mem[0][3]  = 16'hA006;  // JZ 6 (taken)
      mem[0][6]  = 16'h0029;  // LDA 41
      mem[0][7]  = 16'hC02A;  // AND 42
      mem[0][8]  = 16'hA00C;  // JZ 12 (taken)
      mem[0][12] = 16'h800E;  // JMP 14
      mem[0][14] = 16'hE000;  // HLT
      mem[0][41] = 16'h0F0F;
      mem[0][42] = 16'hF0F0;
      expect_txn(0, 0, 0, 0, 0);
      expect_txn(0, 0, 41, 0, 0);
      expect_txn(0, 0, 1, 0, 16'h0F0F);
      expect_txn(0, 0, 2, 0, 16'h0F0F);
      expect_txn(0, 0, 40, 0, 16'h0F0F);
      expect_txn(0, 0, 3, 0, 0);
      expect_txn(0, 0, 6, 0, 0);
      expect_txn(0, 0, 41, 0, 0);
      expect_txn(0, 0, 7, 0, 16'h0F0F);
      expect_txn(0, 0, 42, 0, 16'h0F0F);
      expect_txn(0, 0, 8, 0, 0);
      expect_txn(0, 0, 12, 0, 0);
      expect_txn(0, 0, 14, 0, 0);
      run_to_halt(0, 26, "and_z");
      chk("and_z_acc", 64'(acc[0]), 64'd0);

      // Reset while a store is waiting for its ack
      hold_wr[0] = 1'b1;
      enter_reset(0);
      clear_mem(0);
      mem[0][0]  = 16'h000A;  // LDA 10
      mem[0][1]  = 16'h200C;  // STA 12
      mem[0][10] = 16'h0055;
      expect_txn(0, 0, 0, 0, 0);
      expect_txn(0, 0, 10, 0, 0);
      expect_txn(0, 0, 1, 0, 16'h55);
      expect_txn(0, 1, 12, 16'h55, 16'h55);
      rst_v[0] = 1'b0;
      n = 0;
      while (!(req[0] && we[0]) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mw_reached", 64'(req[0] && we[0]), 64'd1);
      repeat (3) @(posedge clk);
      enter_reset(0);
      chk("mw_rst_pc", 64'(pc[0]), 64'd0);
      chk("mw_rst_acc", 64'(acc[0]), 64'd0);
      chk("mw_rst_halted", 64'(hlt[0]), 64'd0);
      chk("mw_no_write", 64'(mem[0][12]), 64'd0);
      hold_wr[0] = 1'b0;

      // Narrow core: PC wrap from 0xFF, ignored IR bit 8
      enter_reset(1);
      chk("b_rst_pc", 64'(pc[1]), 64'hFF);
      clear_mem(1);
      mem[1][255] = 16'h0110; // LDA 0x10 with bit 8 set
      mem[1][16]  = 16'h0123;
      mem[1][0]   = 16'h0E00; // HLT
      expect_txn(1, 0, 16'hFF, 0, 0);
      expect_txn(1, 0, 16'h10, 0, 0);
      expect_txn(1, 0, 0, 0, 16'h123);
      run_to_halt(1, 6, "wrap");
      chk("wrap_acc", 64'(acc[1]), 64'h123);
      chk("wrap_pc", 64'(pc[1]), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/acc_mc_core.md
# acc_mc_core

Parametrised multicycle accumulator processor core: an integrated controller and datapath executing a 3-bit-opcode, single-address instruction set over one shared memory port. It generalises the fixed 16/13-bit accumulator datapath to configurable data/address widths. It replaces its fixed single-cycle memory with a req/ack handshake that tolerates wait states, and adds SUB, AND, a registered zero flag and a HALT state. It sits between the instruction/data memory (or a memory arbiter) and the top level.

## Interface
- DW, 16, data/instruction width; requires DW >= AW+3
- AW, 13, address width; instruction address field is instr[AW-1:0]
- RESET_PC, 0, PC value loaded at reset (AW bits)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  AW  transaction address
- mem_wdata  out  DW  write data (accumulator)
- mem_rdata  in  DW  read data; sampled in the cycle mem_ack=1
- mem_ack  in  1  transaction complete; ignored while mem_req=0
- halted  out  1  core is in HALT
- dbg_pc  out  AW  current PC
- dbg_acc  out  DW  current accumulator

## Operation
- Opcode = IR[DW-1:DW-3]; operand address = IR[AW-1:0]; bits between them are ignored.
- 000 LDA: acc<=M[a]. 001 STA: M[a]<=acc. 010 ADD: acc<=acc+M[a]. 011 SUB: acc<=acc-M[a]. 100 JMP: pc<=a. 101 JZ: pc<=a if Z=1. 110 AND: acc<=acc&M[a]. 111 HLT.
- Arithmetic is modulo 2^DW; no carry or overflow flag.
- Z is registered and updated only when acc is written (LDA/ADD/SUB/AND): Z<=(new acc==0).
- States:
  - FETCH: req, we=0, addr=pc. On ack: IR<=rdata, pc<=pc+1 mod 2^AW, go to DECODE.
  - DECODE: one cycle, no request.
    - JMP: pc<=a, go to FETCH.
    - JZ: if Z, pc<=a; go to FETCH.
    - HLT: go to HALT.
    - STA: go to MEM_W.
    - Others: go to MEM_R.
  - MEM_R: req, we=0, addr=a. On ack: MDR<=rdata, go to EXEC.
  - EXEC: one cycle. Update acc and Z, go to FETCH.
  - MEM_W: req, we=1, addr=a, wdata=acc. On ack, go to FETCH.
  - HALT: absorbing. halted=1, no requests. Exit only through rst.
- Reset values: state=FETCH, pc=RESET_PC, acc=0, Z=1, IR=0, MDR=0, halted=0.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state and registers only, never from mem_ack. mem_req and mem_we are forced to 0 while rst=1.

## Timing
- Handshake: once mem_req rises, mem_we, mem_addr and mem_wdata stay stable until the cycle in which mem_ack=1. That cycle completes the transaction.
- mem_req drops in the next cycle unless the next state also requests.
- Zero-wait is allowed: ack in the first request cycle completes the transaction in 1 cycle. Each ack-low cycle adds one cycle.
- Zero-wait cycle counts: LDA/ADD/SUB/AND = 4, STA = 3, JMP/JZ = 2, HLT = 2 to reach HALT.
- The first FETCH request appears in the first cycle after rst deasserts.
- Reset mid-transaction: the request is abandoned with no state update. A write whose ack has not arrived must not be counted as done. Memory must tolerate an abandoned request.
- PC wrap: fetching from 2^AW-1 gives pc=0. JMP/JZ take priority over the increment, since they act in DECODE after the increment.

## Test plan
- Program LDA 10; ADD 11; STA 12; HLT with M[10]=5, M[11]=7, zero-wait memory, RESET_PC=0 -> M[12]=12, acc=12, Z=0, halted=1 exactly 13 cycles after rst release, no further requests.
- Same program with ack delayed 3 cycles on every access -> identical result. mem_addr, mem_we and mem_wdata stay constant across each wait window. halted rises at cycle 13+3*7=34.
- SUB underflow, DW=16: acc=3, M[a]=5 -> acc=0xFFFE, Z=0. Then SUB of 0xFFFE -> acc=0, Z=1. A following JZ 20 -> next fetch address 20. With acc nonzero, JZ falls through to pc+1.
- AND/LDA zero: LDA of 0 sets Z=1. AND 0x0F0F with 0xF0F0 -> acc=0, Z=1.
- Wrap and parameters: DW=12, AW=8, RESET_PC=0xFF, instruction at 0xFF = LDA 0x10 -> next fetch address 0x00. Bits IR[8] ignored.
- Reset in MEM_W with ack withheld -> mem_req=0 during rst, no write observed, dbg_pc=RESET_PC, dbg_acc=0, halted=0. Reset while halted -> execution restarts.
